me_bx_scheduler: RTL and testbench

//  Per-BX sequencer for the MatchEngine sector processor. Launches one HLS run per BX period

---
 rtl/me_bx_scheduler.sv | 148 ++++++++++++++
 tb/tb_me_bx_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/me_bx_scheduler.sv
`timescale 1ns/1ps
// me_bx_scheduler: per-BX launcher for the MatchEngine HLS core over ap_ctrl_hs (ap_start/ap_done).
// Latency: me_start rises the cycle after a launch decision; bx_done pulses the cycle after me_done.
// Backpressure: a slot whose previous run is still busy is dropped and counted, never queued.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   go                    run enable level; clr clears drop_cnt/overrun/bx_mismatch
//   me_done, me_bx_out    ap_done and returned bx label from the processor
//   me_start, me_bx       ap_start and bx label driven to the processor
//   busy                  scheduler not idle
//   bx_done, bx_done_id   completion pulse and returned label
//   drop_cnt, overrun     saturating drop count and sticky drop flag
//   bx_mismatch           sticky: returned label differed from the launched one
module me_bx_scheduler #(
    parameter int         BX_PERIOD = 108,
    parameter logic [2:0] BX_INIT   = 3'd0,
    parameter int         CNT_W     = 8,
    parameter int         TIMER_W   = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             go,
    input  logic             clr,
    input  logic             me_done,
    input  logic [2:0]       me_bx_out,
    output logic             me_start,
    output logic [2:0]       me_bx,
    output logic             busy,
    output logic             bx_done,
    output logic [2:0]       bx_done_id,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             overrun,
    output logic             bx_mismatch
);
    localparam logic [TIMER_W-1:0] TICK_AT = TIMER_W'(BX_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         nxt_bx;
    logic               tick;
    logic               launch;
    logic               drop;
    logic               report;
    logic [CNT_W-1:0]   cnt_base;

    assign tick = (timer == TICK_AT);

    // ap_start is masked by ap_done so the core never sees start on its own done cycle;
    // a relaunch on the tick therefore shows a one-cycle low gap.
    assign me_start = (state == ST_RUN) && !me_done;
    assign busy     = (state != ST_IDLE);

    // clr takes effect before any same-cycle drop is added.
    assign cnt_base = clr ? '0 : drop_cnt;

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        drop      = 1'b0;
        report    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    launch    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (me_done) begin
                    // Completion on the tick still counts as on time: relaunch, no drop.
                    report = 1'b1;
                    if (tick && go) begin
                        launch = 1'b1;
                    end else if (go) begin
                        state_nxt = ST_WAIT;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (tick && go) begin
                    drop = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!go) begin
                    state_nxt = ST_IDLE;
                end else if (tick) begin
                    launch    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            timer       <= '0;
            nxt_bx      <= BX_INIT;
            me_bx       <= 3'd0;
            bx_done     <= 1'b0;
            bx_done_id  <= 3'd0;
            drop_cnt    <= '0;
            overrun     <= 1'b0;
            bx_mismatch <= 1'b0;
        end else begin
            state <= state_nxt;

            // Slot phase is anchored at the launch from IDLE and free-runs while active.
            if (state == ST_IDLE) begin
                if (launch) begin
                    timer <= '0;
                end
            end else begin
                timer <= tick ? '0 : timer + TIMER_W'(1);
            end

            if (launch) begin
                me_bx <= nxt_bx;
            end
            // A dropped slot still consumes its label so labels stay aligned to time.
            if (launch || drop) begin
                nxt_bx <= nxt_bx + 3'd1;
            end

            bx_done <= report;
            if (report) begin
                bx_done_id <= me_bx_out;
            end

            if (drop) begin
                drop_cnt <= (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
            end else begin
                drop_cnt <= cnt_base;
            end
            overrun     <= (overrun && !clr) || drop;
            bx_mismatch <= (bx_mismatch && !clr) || (report && (me_bx_out != me_bx));
        end
    end
endmodule

// File: tb/tb_me_bx_scheduler.sv
`timescale 1ns/1ps
// tb_me_bx_scheduler: table-driven, directed and randomized checks of me_bx_scheduler.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 3ns after it.
// Backpressure: an emulated HLS core answers me_start with variable latency, forcing drops.
module tb_me_bx_scheduler;
    localparam int P    = 10;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          go;
    logic          clr;
    logic          me_done;
    logic [2:0]    me_bx_out;
    logic          me_start;
    logic [2:0]    me_bx;
    logic          busy;
    logic          bx_done;
    logic [2:0]    bx_done_id;
    logic [CW-1:0] drop_cnt;
    logic          overrun;
    logic          bx_mismatch;

    int checks   = 0;
    int failures = 0;

    me_bx_scheduler #(
        .BX_PERIOD (P),
        .BX_INIT   (3'd0),
        .CNT_W     (CW),
        .TIMER_W   (8)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (go),
        .clr         (clr),
        .me_done     (me_done),
        .me_bx_out   (me_bx_out),
        .me_start    (me_start),
        .me_bx       (me_bx),
        .busy        (busy),
        .bx_done     (bx_done),
        .bx_done_id  (bx_done_id),
        .drop_cnt    (drop_cnt),
        .overrun     (overrun),
        .bx_mismatch (bx_mismatch)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        go        = 1'b0;
        clr       = 1'b0;
        me_done   = 1'b0;
        me_bx_out = 3'd0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Entered 1ns after an edge; returns at a sample point with me_start high (or bound hit).
    task automatic wait_start(output int n);
        n = 0;
        #2;
        while (me_start !== 1'b1 && n < 40) begin
            @(posedge clk);
            #3;
            n++;
        end
        chk("wait_start", 32'(me_start), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_me_start"}, 32'(me_start), 0);
        chk({tag, "_me_bx"}, 32'(me_bx), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_bx_done"}, 32'(bx_done), 0);
        chk({tag, "_bx_done_id"}, 32'(bx_done_id), 0);
        chk({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_bx_mismatch"}, 32'(bx_mismatch), 0);
    endtask

    // ---------------- table of per-cycle vectors ----------------
    typedef struct {
        int         n;
        bit         go;
        bit         done;
        logic [2:0] bxo;
        bit         e_start;
        logic [2:0] e_bx;
        bit         e_busy;
        bit         e_bd;
        logic [2:0] e_id;
    } row_t;

    row_t tbl[$];

    function automatic row_t mk(int n, bit g, bit d, logic [2:0] bo, bit es,
                                logic [2:0] eb, bit ebusy, bit ebd, logic [2:0] eid);
        row_t r;
        r.n = n; r.go = g; r.done = d; r.bxo = bo; r.e_start = es;
        r.e_bx = eb; r.e_busy = ebusy; r.e_bd = ebd; r.e_id = eid;
        return r;
    endfunction

    // ---------------- behavioural reference ----------------
    // Slot phase is (cycle - anchor) mod P, anchor = first active cycle after an idle launch.
    bit m_run, m_wait, m_ovr, m_mm, m_bd;
    int m_bx, m_lbl, m_drops, m_cyc, m_anchor, m_id;

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_ovr = 0; m_mm = 0; m_bd = 0;
        m_bx = 0; m_lbl = 0; m_drops = 0; m_cyc = 0; m_anchor = 0; m_id = 0;
    endtask

    task automatic model_launch();
        m_bx  = m_lbl;
        m_lbl = (m_lbl + 1) % 8;
    endtask

    task automatic model_step(input bit i_go, input bit i_clr, input bit i_done, input logic [2:0] i_bxo);
        bit tk;
        tk   = (m_run || m_wait) && (((m_cyc - m_anchor) % P) == P - 1);
        m_bd = 0;
        if (i_clr) begin
            m_drops = 0; m_ovr = 0; m_mm = 0;
        end
        if (m_run) begin
            if (i_done) begin
                m_bd = 1;
                m_id = int'(i_bxo);
                if (int'(i_bxo) != m_bx) m_mm = 1;
                if (tk && i_go) model_launch();
                else begin
                    m_run  = 0;
                    m_wait = i_go;
                end
            end else if (tk && i_go) begin
                if (m_drops < CMAX) m_drops++;
                m_ovr = 1;
                m_lbl = (m_lbl + 1) % 8;
            end
        end else if (m_wait) begin
            if (!i_go) m_wait = 0;
            else if (tk) begin
                m_wait = 0;
                m_run  = 1;
                model_launch();
            end
        end else if (i_go) begin
            m_run    = 1;
            m_anchor = m_cyc + 1;
            model_launch();
        end
        m_cyc++;
    endtask

    // Emulated HLS core state for the random phase.
    bit         proc_busy;
    int         proc_cnt;
    logic [2:0] proc_bx;
    bit         last_start;
    logic [2:0] last_bx;

    initial begin
        int         n;
        logic [2:0] lbl;

        // ---------- table-driven sequence from reset ----------
        tbl.push_back(mk(1, 0, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0));
        tbl.push_back(mk(1, 1, 0, 3'd0, 0, 3'd0, 0, 0, 3'd0));
        tbl.push_back(mk(4, 1, 0, 3'd0, 1, 3'd0, 1, 0, 3'd0));
        tbl.push_back(mk(1, 1, 1, 3'd0, 0, 3'd0, 1, 0, 3'd0));
        tbl.push_back(mk(1, 1, 0, 3'd0, 0, 3'd0, 1, 1, 3'd0));
        tbl.push_back(mk(4, 1, 0, 3'd0, 0, 3'd0, 1, 0, 3'd0));
        tbl.push_back(mk(9, 1, 0, 3'd0, 1, 3'd1, 1, 0, 3'd0));
        tbl.push_back(mk(1, 1, 1, 3'd1, 0, 3'd1, 1, 0, 3'd0));  // done on the tick
        tbl.push_back(mk(1, 1, 0, 3'd0, 1, 3'd2, 1, 1, 3'd1));
        tbl.push_back(mk(1, 0, 0, 3'd0, 1, 3'd2, 1, 0, 3'd0));  // go drops mid-run
        tbl.push_back(mk(9, 0, 0, 3'd0, 1, 3'd2, 1, 0, 3'd0));  // tick with go=0: no drop
        tbl.push_back(mk(1, 0, 1, 3'd2, 0, 3'd2, 1, 0, 3'd0));
        tbl.push_back(mk(1, 0, 0, 3'd0, 0, 3'd2, 0, 1, 3'd2));
        tbl.push_back(mk(1, 0, 0, 3'd0, 0, 3'd2, 0, 0, 3'd0));
        tbl.push_back(mk(1, 1, 0, 3'd0, 0, 3'd2, 0, 0, 3'd0));
        tbl.push_back(mk(1, 1, 0, 3'd0, 1, 3'd3, 1, 0, 3'd0));

        do_reset();
        foreach (tbl[i]) begin
            for (int r = 0; r < tbl[i].n; r++) begin
                go        = tbl[i].go;
                clr       = 1'b0;
                me_done   = tbl[i].done;
                me_bx_out = tbl[i].bxo;
                #2;
                chk($sformatf("T%0d_me_start", i), 32'(me_start), 32'(tbl[i].e_start));
                chk($sformatf("T%0d_me_bx", i), 32'(me_bx), 32'(tbl[i].e_bx));
                chk($sformatf("T%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
                chk($sformatf("T%0d_bx_done", i), 32'(bx_done), 32'(tbl[i].e_bd));
                if (tbl[i].e_bd)
                    chk($sformatf("T%0d_bx_done_id", i), 32'(bx_done_id), 32'(tbl[i].e_id));
                chk($sformatf("T%0d_drop_cnt", i), 32'(drop_cnt), 0);
                chk($sformatf("T%0d_overrun", i), 32'(overrun), 0);
                chk($sformatf("T%0d_bx_mismatch", i), 32'(bx_mismatch), 0);
                step();
            end
        end

        // ---------- done held off past the tick: one drop ----------
        do_reset();
        #2;
        chk_all_zero("A_reset");
        step();
        go = 1'b1;
        wait_start(n);
        chk("A_first_label", 32'(me_bx), 0);
        for (int k = 0; k < 13; k++) begin
            if (k == 10) begin
                chk("A_drop_cnt", 32'(drop_cnt), 1);
                chk("A_overrun", 32'(overrun), 1);
                chk("A_start_held", 32'(me_start), 1);
            end
            step();
            if (k == 12) begin
                me_done   = 1'b1;
                me_bx_out = 3'd0;
            end
            #2;
        end
        chk("A_start_low_on_done", 32'(me_start), 0);
        step();
        me_done = 1'b0;
        #2;
        chk("A_bx_done", 32'(bx_done), 1);
        chk("A_wait_busy", 32'(busy), 1);
        chk("A_wait_no_start", 32'(me_start), 0);
        chk("A_no_mismatch", 32'(bx_mismatch), 0);
        step();
        wait_start(n);
        chk("A_gap_to_relaunch", 32'(n), 5);
        chk("A_next_label", 32'(me_bx), 2);

        // ---------- label mismatch, clr, saturation ----------
        do_reset();
        go = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_start(n);
            chk("B_seq_label", 32'(me_bx), 32'(i));
            lbl = me_bx;
            step();
            step();
            me_done   = 1'b1;
            me_bx_out = (i == 3) ? 3'd5 : lbl;
            #2;
            chk("B_start_low_on_done", 32'(me_start), 0);
            step();
            me_done = 1'b0;
            #2;
            chk("B_bx_done", 32'(bx_done), 1);
            chk("B_bx_done_id", 32'(bx_done_id), (i == 3) ? 32'd5 : 32'(i));
            chk("B_bx_mismatch", 32'(bx_mismatch), (i == 3) ? 32'd1 : 32'd0);
            step();
        end
        clr = 1'b1;
        #2;
        chk("B_mismatch_before_clr", 32'(bx_mismatch), 1);
        step();
        clr = 1'b0;
        #2;
        chk("B_mismatch_cleared", 32'(bx_mismatch), 0);
        step();
        wait_start(n);
        for (int k = 0; k < 3010; k++) begin
            if (k == 2540) chk("B_drop_254", 32'(drop_cnt), 254);
            if (k == 3000) begin
                chk("B_drop_sat", 32'(drop_cnt), 255);
                chk("B_overrun_set", 32'(overrun), 1);
                chk("B_start_while_dropping", 32'(me_start), 1);
            end
            step();
            clr = (k + 1 == 3009);
            #2;
        end
        chk("B_clr_with_drop", 32'(drop_cnt), 1);
        chk("B_overrun_after_clr_drop", 32'(overrun), 1);

        // ---------- asynchronous reset mid-run ----------
        chk("C_running", 32'(me_start), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_all_zero("C_async");
        @(posedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_start(n);
        chk("C_restart_latency", 32'(n), 1);
        chk("C_first_label", 32'(me_bx), 0);
        step();

        // ---------- randomized run against the reference ----------
        do_reset();
        model_reset();
        go         = 1'b1;
        proc_busy  = 0;
        proc_cnt   = 0;
        proc_bx    = 3'd0;
        last_start = 0;
        last_bx    = 3'd0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) go = ~go;
            clr       = ($urandom_range(0, 99) < 2);
            me_done   = 1'b0;
            me_bx_out = 3'($urandom_range(0, 7));
            if (proc_busy) begin
                if (proc_cnt == 0) begin
                    me_done   = 1'b1;
                    proc_busy = 0;
                    me_bx_out = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(0, 7)) : proc_bx;
                end else begin
                    proc_cnt--;
                end
            end else if (last_start) begin
                proc_busy = 1;
                proc_cnt  = int'($urandom_range(1, 14));
                proc_bx   = last_bx;
            end else if ($urandom_range(0, 39) == 0) begin
                me_done = 1'b1;
            end
            #2;
            chk("R_me_start", 32'(me_start), 32'(m_run && !me_done));
            chk("R_me_bx", 32'(me_bx), m_bx);
            chk("R_busy", 32'(busy), 32'(m_run || m_wait));
            chk("R_bx_done", 32'(bx_done), 32'(m_bd));
            if (m_bd) chk("R_bx_done_id", 32'(bx_done_id), m_id);
            chk("R_drop_cnt", 32'(drop_cnt), m_drops);
            chk("R_overrun", 32'(overrun), 32'(m_ovr));
            chk("R_bx_mismatch", 32'(bx_mismatch), 32'(m_mm));
            last_start = me_start;
            last_bx    = me_bx;
            model_step(go, clr, me_done, me_bx_out);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
